conv_host_mem: RTL and testbench



---
 rtl/conv_host_mem.sv | 206 ++++++++++++++++++++
 tb/tb_conv_host_mem.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_host_mem.sv
// conv_host_mem: host-side responder for the CONV engine.
// Holds the 64x64 image and the Layer-0 / Layer-1 result memories, answers the
// engine's image-read and layer read/write buses, runs the ready/busy start
// handshake, and offers an image load port plus a result readback port.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; image load allowed
// ST_ARM   | ready=1, waiting for engine busy (bounded by ARM_TIMEOUT)
// ST_RUN   | engine working; layer buses active
// ST_DONE  | engine finished; done=1, image load allowed, start reruns
module conv_host_mem #(
    parameter int IMG_DEPTH   = 4096,
    parameter int L0_DEPTH    = 4096,
    parameter int L1_DEPTH    = 1024,
    parameter int ARM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        ready,
    input  logic        busy,
    input  logic [11:0] iaddr,
    output logic [19:0] idata,
    input  logic        cwr,
    input  logic [11:0] caddr_wr,
    input  logic [19:0] cdata_wr,
    input  logic        crd,
    input  logic [11:0] caddr_rd,
    output logic [19:0] cdata_rd,
    input  logic [2:0]  csel,
    input  logic        ld_we,
    input  logic [11:0] ld_addr,
    input  logic [19:0] ld_data,
    input  logic        rb_sel,
    input  logic [11:0] rb_addr,
    output logic [19:0] rb_data,
    output logic        done,
    output logic        err,
    output logic [12:0] l0_wr_cnt,
    output logic [10:0] l1_wr_cnt
);

    localparam int              TMR_W    = $clog2(ARM_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ARM_TIMEOUT - 1);
    localparam logic [2:0]      CSEL_L0  = 3'b001;
    localparam logic [2:0]      CSEL_L1  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TMR_W-1:0] r_tmr;
    logic [TMR_W-1:0] w_tmr_nxt;
    logic             w_timeout;
    logic             w_run_start;

    logic             r_ready;
    logic             r_done;
    logic             r_err;
    logic [12:0]      r_l0_cnt;
    logic [10:0]      r_l1_cnt;

    logic [19:0]      r_img [IMG_DEPTH];
    logic [19:0]      r_l0  [L0_DEPTH];
    logic [19:0]      r_l1  [L1_DEPTH];

    logic             w_sel_l0;
    logic             w_sel_l1;
    logic             w_sel_bad;
    logic             w_l1_hi_addr;
    logic             w_quiet;
    logic             w_wr_l0;
    logic             w_wr_l1;
    logic             w_err_set;
    logic [19:0]      w_cdata_rd;

    // Bank decode and protocol error detection for the layer buses.
    assign w_sel_l0     = (csel == CSEL_L0);
    assign w_sel_l1     = (csel == CSEL_L1);
    assign w_sel_bad    = !(w_sel_l0 || w_sel_l1);
    assign w_l1_hi_addr = (caddr_wr[11:10] != 2'b00);
    assign w_quiet      = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_wr_l0      = cwr && w_sel_l0;
    assign w_wr_l1      = cwr && w_sel_l1 && !w_l1_hi_addr;
    assign w_err_set    = (cwr && w_sel_bad)
                        || (cwr && w_sel_l1 && w_l1_hi_addr)
                        || (crd && w_sel_bad)
                        || ((cwr || crd) && w_quiet);

    // Next-state logic; the ARM timer counts down and fires at terminal count.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_timeout   = 1'b0;
        w_run_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_ARM;
                    w_tmr_nxt   = TMR_LOAD;
                    w_run_start = 1'b1;
                end
            end
            ST_ARM: begin
                if (busy) begin
                    w_state_nxt = ST_RUN;
                end else if (r_tmr == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_timeout   = 1'b1;
                end else begin
                    w_tmr_nxt = r_tmr - TMR_W'(1);
                end
            end
            ST_RUN: begin
                if (!busy) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_ARM;
                    w_tmr_nxt   = TMR_LOAD;
                    w_run_start = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, handshake flags, sticky error and saturating write counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_tmr    <= '0;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_l0_cnt <= '0;
            r_l1_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_ready <= (w_state_nxt == ST_ARM);
            r_done  <= (w_state_nxt == ST_DONE);
            r_err   <= r_err || w_err_set || w_timeout;
            if (w_run_start) begin
                r_l0_cnt <= '0;
                r_l1_cnt <= '0;
            end else begin
                if (w_wr_l0 && (r_l0_cnt != '1)) begin
                    r_l0_cnt <= r_l0_cnt + 13'd1;
                end
                if (w_wr_l1 && (r_l1_cnt != '1)) begin
                    r_l1_cnt <= r_l1_cnt + 11'd1;
                end
            end
        end
    end

    // Image load is only accepted while the engine is not using the image.
    always_ff @(posedge clk) begin
        if (ld_we && w_quiet) begin
            r_img[ld_addr] <= ld_data;
        end
    end

    // Layer result writes; dropped writes never touch the arrays.
    always_ff @(posedge clk) begin
        if (w_wr_l0) begin
            r_l0[caddr_wr] <= cdata_wr;
        end
        if (w_wr_l1) begin
            r_l1[caddr_wr[9:0]] <= cdata_wr;
        end
    end

    // Layer read mux; idle or illegal selections read as zero.
    always_comb begin
        w_cdata_rd = '0;
        if (crd) begin
            if (w_sel_l0) begin
                w_cdata_rd = r_l0[caddr_rd];
            end else if (w_sel_l1) begin
                w_cdata_rd = r_l1[caddr_rd[9:0]];
            end
        end
    end

    assign idata     = r_img[iaddr];
    assign cdata_rd  = w_cdata_rd;
    assign rb_data   = rb_sel ? r_l1[rb_addr[9:0]] : r_l0[rb_addr];
    assign ready     = r_ready;
    assign done      = r_done;
    assign err       = r_err;
    assign l0_wr_cnt = r_l0_cnt;
    assign l1_wr_cnt = r_l1_cnt;

endmodule

// File: tb/tb_conv_host_mem.sv
// Directed testbench for conv_host_mem: handshake, image port, layer banks,
// error flagging, ARM timeout and asynchronous reset.
module tb_conv_host_mem;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        ready;
    logic        busy = 1'b0;
    logic [11:0] iaddr = '0;
    logic [19:0] idata;
    logic        cwr = 1'b0;
    logic [11:0] caddr_wr = '0;
    logic [19:0] cdata_wr = '0;
    logic        crd = 1'b0;
    logic [11:0] caddr_rd = '0;
    logic [19:0] cdata_rd;
    logic [2:0]  csel = 3'b001;
    logic        ld_we = 1'b0;
    logic [11:0] ld_addr = '0;
    logic [19:0] ld_data = '0;
    logic        rb_sel = 1'b0;
    logic [11:0] rb_addr = '0;
    logic [19:0] rb_data;
    logic        done;
    logic        err;
    logic [12:0] l0_wr_cnt;
    logic [10:0] l1_wr_cnt;

    int n_total = 0;
    int n_pass  = 0;

    conv_host_mem dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .rb_sel(rb_sel), .rb_addr(rb_addr), .rb_data(rb_data),
        .done(done), .err(err), .l0_wr_cnt(l0_wr_cnt), .l1_wr_cnt(l1_wr_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        busy  = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_total++;
        if ({ready, done, err} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {ready, done, err});
        else n_pass++;
        n_total++;
        if ({l0_wr_cnt, l1_wr_cnt} !== 24'd0) $display("FAIL reset_counters: got %h expected 0", {l0_wr_cnt, l1_wr_cnt});
        else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_image_load();
        ld_we = 1'b1; ld_addr = 12'h041; ld_data = 20'h12345;
        tick();
        ld_addr = 12'h000; ld_data = 20'hFFFFF;
        tick();
        ld_we = 1'b0;
        iaddr = 12'h041;
        #1;
        n_total++;
        if (idata !== 20'h12345) $display("FAIL img_read_041: got %h expected 12345", idata);
        else n_pass++;
        iaddr = 12'h000;
        #1;
        n_total++;
        if (idata !== 20'hFFFFF) $display("FAIL img_read_000: got %h expected fffff", idata);
        else n_pass++;
    endtask

    task automatic test_handshake_and_layers();
        int  rcnt = 0;
        bit  seen = 1'b0;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            if (ready) rcnt++;
            if (seen) busy = 1'b1;
            seen = seen | ready;
            tick();
        end
        n_total++;
        if (rcnt !== 2) $display("FAIL ready_high_cycles: got %0d expected 2", rcnt);
        else n_pass++;

        // load attempt while running must not change the image
        ld_we = 1'b1; ld_addr = 12'h041; ld_data = 20'h55555;
        tick();
        ld_we = 1'b0;
        iaddr = 12'h041;
        #1;
        n_total++;
        if (idata !== 20'h12345) $display("FAIL img_load_in_run: got %h expected 12345", idata);
        else n_pass++;

        cwr = 1'b1; csel = 3'b001; caddr_wr = 12'hFFF; cdata_wr = 20'h0ABCD;
        tick();
        cwr = 1'b0;
        crd = 1'b1; caddr_rd = 12'hFFF;
        #1;
        n_total++;
        if (cdata_rd !== 20'h0ABCD) $display("FAIL l0_read: got %h expected 0abcd", cdata_rd);
        else n_pass++;
        n_total++;
        if (l0_wr_cnt !== 13'd1) $display("FAIL l0_cnt_1: got %0d expected 1", l0_wr_cnt);
        else n_pass++;

        // same-cycle write and read: old value now, new value next cycle
        cwr = 1'b1; cdata_wr = 20'h11111;
        #1;
        n_total++;
        if (cdata_rd !== 20'h0ABCD) $display("FAIL rw_same_old: got %h expected 0abcd", cdata_rd);
        else n_pass++;
        tick();
        cwr = 1'b0;
        n_total++;
        if (cdata_rd !== 20'h11111) $display("FAIL rw_same_new: got %h expected 11111", cdata_rd);
        else n_pass++;

        crd = 1'b0;
        cwr = 1'b1; csel = 3'b011; caddr_wr = 12'h3FF; cdata_wr = 20'h00777;
        tick();
        cwr = 1'b0;
        rb_sel = 1'b1; rb_addr = 12'h3FF;
        #1;
        n_total++;
        if (rb_data !== 20'h00777) $display("FAIL l1_readback: got %h expected 00777", rb_data);
        else n_pass++;
        crd = 1'b1; caddr_rd = 12'h3FF;
        #1;
        n_total++;
        if (cdata_rd !== 20'h00777) $display("FAIL l1_read: got %h expected 00777", cdata_rd);
        else n_pass++;
        crd = 1'b0;
        #1;
        n_total++;
        if (cdata_rd !== 20'h00000) $display("FAIL rd_idle_zero: got %h expected 00000", cdata_rd);
        else n_pass++;
        n_total++;
        if ({err, l0_wr_cnt, l1_wr_cnt} !== {1'b0, 13'd2, 11'd1}) $display("FAIL run_status: got err=%b l0=%0d l1=%0d expected err=0 l0=2 l1=1", err, l0_wr_cnt, l1_wr_cnt);
        else n_pass++;

        repeat (100) tick();
        busy = 1'b0;
        #1;
        n_total++;
        if (done !== 1'b0) $display("FAIL done_early: got %b expected 0", done);
        else n_pass++;
        tick();
        n_total++;
        if ({done, ready} !== 2'b10) $display("FAIL done_after_busy: got %b expected 10", {done, ready});
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        n_total++;
        if ({done, ready, l0_wr_cnt} !== {2'b01, 13'd0}) $display("FAIL restart_clear: got done=%b ready=%b l0=%0d expected 0 1 0", done, ready, l0_wr_cnt);
        else n_pass++;
        tick();
        busy = 1'b1;
        tick();
        cwr = 1'b1; csel = 3'b001; caddr_wr = 12'h010; cdata_wr = 20'h0F0F0;
        tick();
        cwr = 1'b0;
        n_total++;
        if (l0_wr_cnt !== 13'd1) $display("FAIL pre_reset_cnt: got %0d expected 1", l0_wr_cnt);
        else n_pass++;
        reset = 1'b1; busy = 1'b0;
        #2;
        n_total++;
        if ({ready, done, l0_wr_cnt, l1_wr_cnt} !== 26'd0) $display("FAIL async_reset_run: got %h expected 0", {ready, done, l0_wr_cnt, l1_wr_cnt});
        else n_pass++;
        tick();
        reset = 1'b0;
        tick();

        pulse_start();
        n_total++;
        if (ready !== 1'b1) $display("FAIL arm_ready: got %b expected 1", ready);
        else n_pass++;
        reset = 1'b1;
        #2;
        n_total++;
        if (ready !== 1'b0) $display("FAIL async_reset_arm: got %b expected 0", ready);
        else n_pass++;
        tick();
        reset = 1'b0;
        rb_sel = 1'b0; rb_addr = 12'h010;
        #1;
        n_total++;
        if (rb_data !== 20'h0F0F0) $display("FAIL retain_l0_010: got %h expected 0f0f0", rb_data);
        else n_pass++;
        rb_addr = 12'hFFF;
        #1;
        n_total++;
        if (rb_data !== 20'h11111) $display("FAIL retain_l0_fff: got %h expected 11111", rb_data);
        else n_pass++;
        tick();
    endtask

    task automatic test_timeout();
        int early = 0;
        busy = 1'b0;
        pulse_start();
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (err !== 1'b0 || ready !== 1'b1) early++;
        end
        n_total++;
        if (early !== 0) $display("FAIL timeout_early: got %0d bad cycles expected 0", early);
        else n_pass++;
        tick();
        n_total++;
        if ({err, ready} !== 2'b10) $display("FAIL timeout_fire: got err/ready=%b expected 10", {err, ready});
        else n_pass++;
        // back in IDLE: image loads are accepted again
        ld_we = 1'b1; ld_addr = 12'h041; ld_data = 20'h22222;
        tick();
        ld_we = 1'b0;
        iaddr = 12'h041;
        #1;
        n_total++;
        if (idata !== 20'h22222) $display("FAIL timeout_idle_load: got %h expected 22222", idata);
        else n_pass++;
    endtask

    task automatic test_errors();
        do_reset();
        pulse_start();
        tick();
        busy = 1'b1;
        tick();
        n_total++;
        if (err !== 1'b0) $display("FAIL err_clear: got %b expected 0", err);
        else n_pass++;
        cwr = 1'b1; csel = 3'b011; caddr_wr = 12'h000; cdata_wr = 20'h12121;
        tick();
        csel = 3'b010; caddr_wr = 12'h005; cdata_wr = 20'h00003;
        tick();
        cwr = 1'b0;
        n_total++;
        if ({err, l0_wr_cnt, l1_wr_cnt} !== {1'b1, 13'd0, 11'd1}) $display("FAIL err_bad_csel: got err=%b l0=%0d l1=%0d expected 1 0 1", err, l0_wr_cnt, l1_wr_cnt);
        else n_pass++;
        cwr = 1'b1; csel = 3'b011; caddr_wr = 12'h400; cdata_wr = 20'hAAAAA;
        tick();
        cwr = 1'b0;
        rb_sel = 1'b1; rb_addr = 12'h000;
        #1;
        n_total++;
        if (rb_data !== 20'h12121) $display("FAIL l1_hi_addr_drop: got %h expected 12121", rb_data);
        else n_pass++;
        n_total++;
        if (l1_wr_cnt !== 11'd1) $display("FAIL l1_hi_addr_cnt: got %0d expected 1", l1_wr_cnt);
        else n_pass++;
        repeat (5) tick();
        n_total++;
        if (err !== 1'b1) $display("FAIL err_sticky: got %b expected 1", err);
        else n_pass++;
        do_reset();
        n_total++;
        if (err !== 1'b0) $display("FAIL err_reset: got %b expected 0", err);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_image_load();
        test_handshake_and_layers();
        test_reset_mid_run();
        test_timeout();
        test_errors();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
